multicycle_ctrl: RTL and testbench



---
 rtl/mc_pkg.sv | 42 ++++
 rtl/multicycle_ctrl_if.sv | 36 +++
 rtl/alu_decoder.sv | 21 ++
 rtl/multicycle_ctrl_core.sv | 164 ++++++++++++++++
 rtl/multicycle_ctrl.sv | 50 +++++
 tb/tb_multicycle_ctrl.sv | 286 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle MIPS-subset controller:
// state encoding, opcode/funct values and ALU operation codes.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_FWAIT  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MRWAIT = 4'd5,
    S_MEMWB  = 4'd6,
    S_MEMWR  = 4'd7,
    S_EXEC   = 4'd8,
    S_RWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_ADDIEX = 4'd12,
    S_ADDIWB = 4'd13,
    S_HALT   = 4'd14
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction-field inputs and datapath control outputs of the controller.
interface multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_source;
  logic       pc_we;
  logic       illegal;
  logic [3:0] state_dbg;

  modport master (
    output op, funct, zero,
    input  iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_control, pc_write, pc_write_cond,
           pc_source, pc_we, illegal, state_dbg
  );

  modport slave (
    input  op, funct, zero,
    output iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_control, pc_write, pc_write_cond,
           pc_source, pc_we, illegal, state_dbg
  );
endinterface

// File: rtl/alu_decoder.sv
// R-type funct field to ALU operation; valid=0 flags an unsupported funct.
module alu_decoder
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       valid
);
  always_comb begin
    alu_control = ALU_ADD;
    valid       = 1'b1;
    case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_SUB:  alu_control = ALU_SUB;
      FN_AND:  alu_control = ALU_AND;
      FN_OR:   alu_control = ALU_OR;
      FN_SLT:  alu_control = ALU_SLT;
      default: valid = 1'b0;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl_core.sv
// Moore control FSM. Instruction fields are captured in DECODE so later
// states drive outputs from registered state only.
module multicycle_ctrl_core
  import mc_pkg::*;
(
  input logic clk,
  input logic rst,
  multicycle_ctrl_if.slave bus
);
  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [2:0] alu_ctl_q, alu_ctl_d;
  logic       alu_ok_q, alu_ok_d;
  logic       is_sw_q, is_sw_d;
  logic [2:0] dec_ctl;
  logic       dec_ok;

  logic       iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, pc_write, pc_write_cond;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_control;

  alu_decoder u_alu_dec (.funct(bus.funct), .alu_control(dec_ctl), .valid(dec_ok));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      alu_ctl_q <= ALU_ADD;
      alu_ok_q  <= 1'b0;
      is_sw_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      alu_ctl_q <= alu_ctl_d;
      alu_ok_q  <= alu_ok_d;
      is_sw_q   <= is_sw_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    alu_ctl_d     = alu_ctl_q;
    alu_ok_d      = alu_ok_q;
    is_sw_d       = is_sw_q;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_control   = 3'b000;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        state_d  = S_FWAIT;
      end
      S_FWAIT: begin
        ir_write    = 1'b1;
        alu_src_b   = 2'b01;
        alu_control = ALU_ADD;
        pc_write    = 1'b1;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is precomputed into ALUOut while dispatching.
        alu_src_b   = 2'b11;
        alu_control = ALU_ADD;
        alu_ctl_d   = dec_ctl;
        alu_ok_d    = dec_ok;
        is_sw_d     = (bus.op == OP_SW);
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_HALT;
        endcase
      end
      S_MEMADR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
        state_d     = is_sw_q ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        state_d  = S_MRWAIT;
      end
      S_MRWAIT: state_d = S_MEMWB;
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_read  = 1'b1;
        mem_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a   = 1'b1;
        alu_control = alu_ctl_q;
        state_d     = alu_ok_q ? S_RWB : S_HALT;
      end
      S_RWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_control   = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
        state_d     = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
    // Flag rises on the same edge that enters HALT and stays until reset.
    illegal_d = illegal_q | (state_d == S_HALT);
  end

  assign bus.iord          = iord;
  assign bus.mem_read      = mem_read;
  assign bus.mem_write     = mem_write;
  assign bus.ir_write      = ir_write;
  assign bus.reg_dst       = reg_dst;
  assign bus.mem_to_reg    = mem_to_reg;
  assign bus.reg_write     = reg_write;
  assign bus.alu_src_a     = alu_src_a;
  assign bus.alu_src_b     = alu_src_b;
  assign bus.alu_control   = alu_control;
  assign bus.pc_write      = pc_write;
  assign bus.pc_write_cond = pc_write_cond;
  assign bus.pc_source     = pc_source;
  assign bus.pc_we         = pc_write | (pc_write_cond & bus.zero);
  assign bus.illegal       = illegal_q;
  assign bus.state_dbg     = state_q;
endmodule

// File: rtl/multicycle_ctrl.sv
// Flat-port top of the multicycle controller; bundles ports onto the
// controller interface and hands it to the FSM core.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       pc_we,
  output logic       illegal,
  output logic [3:0] state_dbg
);
  multicycle_ctrl_if bus ();

  assign bus.op    = op;
  assign bus.funct = funct;
  assign bus.zero  = zero;

  multicycle_ctrl_core u_core (.clk(clk), .rst(rst), .bus(bus.slave));

  assign iord          = bus.iord;
  assign mem_read      = bus.mem_read;
  assign mem_write     = bus.mem_write;
  assign ir_write      = bus.ir_write;
  assign reg_dst       = bus.reg_dst;
  assign mem_to_reg    = bus.mem_to_reg;
  assign reg_write     = bus.reg_write;
  assign alu_src_a     = bus.alu_src_a;
  assign alu_src_b     = bus.alu_src_b;
  assign alu_control   = bus.alu_control;
  assign pc_write      = bus.pc_write;
  assign pc_write_cond = bus.pc_write_cond;
  assign pc_source     = bus.pc_source;
  assign pc_we         = bus.pc_we;
  assign illegal       = bus.illegal;
  assign state_dbg     = bus.state_dbg;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl: walks each instruction class
// state by state and checks the Moore outputs against hand-derived values.
module tb_multicycle_ctrl;
  localparam logic [3:0] FETCH = 4'd0, FWAIT = 4'd1, DECODE = 4'd2, MEMADR = 4'd3,
                         MEMRD = 4'd4, MRWAIT = 4'd5, MEMWB = 4'd6, MEMWR = 4'd7,
                         EXEC = 4'd8, RWB = 4'd9, BRANCH = 4'd10, JUMP = 4'd11,
                         ADDIEX = 4'd12, ADDIWB = 4'd13, HALT = 4'd14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .op(bus.op), .funct(bus.funct), .zero(bus.zero),
    .iord(bus.iord), .mem_read(bus.mem_read), .mem_write(bus.mem_write),
    .ir_write(bus.ir_write), .reg_dst(bus.reg_dst), .mem_to_reg(bus.mem_to_reg),
    .reg_write(bus.reg_write), .alu_src_a(bus.alu_src_a), .alu_src_b(bus.alu_src_b),
    .alu_control(bus.alu_control), .pc_write(bus.pc_write),
    .pc_write_cond(bus.pc_write_cond), .pc_source(bus.pc_source), .pc_we(bus.pc_we),
    .illegal(bus.illegal), .state_dbg(bus.state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.op = 6'b000000; bus.funct = 6'b100000; bus.zero = 1'b0;
    rst = 1'b1;
    #3;
    n_checks++;
    if (bus.state_dbg !== FETCH) begin n_fail++;
      $display("FAIL reset_state got=%0d exp=%0d", bus.state_dbg, FETCH); end
    n_checks++;
    if ({bus.mem_read, bus.iord, bus.illegal} !== 3'b100) begin n_fail++;
      $display("FAIL reset_outs mem_read/iord/illegal got=%b exp=100",
               {bus.mem_read, bus.iord, bus.illegal}); end
    n_checks++;
    if ({bus.mem_write, bus.reg_write, bus.ir_write, bus.pc_write, bus.pc_write_cond, bus.pc_we} !== 6'b0) begin
      n_fail++; $display("FAIL reset_enables got=%b exp=000000",
        {bus.mem_write, bus.reg_write, bus.ir_write, bus.pc_write, bus.pc_write_cond, bus.pc_we}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_rtype();
    logic [3:0] exp_s [5] = '{FETCH, FWAIT, DECODE, EXEC, RWB};
    bus.op = 6'b000000; bus.funct = 6'b100000;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (bus.state_dbg !== exp_s[i]) begin n_fail++;
        $display("FAIL rtype_state[%0d] got=%0d exp=%0d", i, bus.state_dbg, exp_s[i]); end
      n_checks++;
      if ({bus.reg_write, bus.reg_dst} !== ((i == 4) ? 2'b11 : 2'b00)) begin n_fail++;
        $display("FAIL rtype_regwr[%0d] got=%b", i, {bus.reg_write, bus.reg_dst}); end
      if (i == 1) begin
        n_checks++;
        if ({bus.ir_write, bus.pc_write, bus.pc_we, bus.alu_src_b} !== 5'b11101) begin n_fail++;
          $display("FAIL fwait_outs got=%b exp=11101", {bus.ir_write, bus.pc_write, bus.pc_we, bus.alu_src_b}); end
      end
      if (i == 3) begin
        n_checks++;
        if ({bus.alu_control, bus.alu_src_a, bus.alu_src_b} !== 6'b010100) begin n_fail++;
          $display("FAIL exec_add got=%b exp=010100", {bus.alu_control, bus.alu_src_a, bus.alu_src_b}); end
      end
      tick();
    end
    n_checks++;
    if (bus.state_dbg !== FETCH) begin n_fail++;
      $display("FAIL rtype_end got=%0d exp=%0d", bus.state_dbg, FETCH); end
    // SUB and SLT through EXEC
    bus.funct = 6'b100010;
    tick(); tick(); tick();
    n_checks++;
    if (bus.alu_control !== 3'b110) begin n_fail++;
      $display("FAIL exec_sub got=%b exp=110", bus.alu_control); end
    tick(); tick();
    bus.funct = 6'b101010;
    tick(); tick(); tick();
    n_checks++;
    if (bus.alu_control !== 3'b111) begin n_fail++;
      $display("FAIL exec_slt got=%b exp=111", bus.alu_control); end
    tick(); tick();
  endtask

  task automatic test_lw();
    logic [3:0] exp_s [7] = '{FETCH, FWAIT, DECODE, MEMADR, MEMRD, MRWAIT, MEMWB};
    bus.op = 6'b100011;
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (bus.state_dbg !== exp_s[i]) begin n_fail++;
        $display("FAIL lw_state[%0d] got=%0d exp=%0d", i, bus.state_dbg, exp_s[i]); end
      if (i == 3) begin
        n_checks++;
        if ({bus.alu_src_a, bus.alu_src_b, bus.alu_control} !== 6'b110010) begin n_fail++;
          $display("FAIL lw_memadr got=%b exp=110010", {bus.alu_src_a, bus.alu_src_b, bus.alu_control}); end
      end
      if (i == 4) begin
        n_checks++;
        if ({bus.iord, bus.mem_read, bus.mem_write} !== 3'b110) begin n_fail++;
          $display("FAIL lw_memrd got=%b exp=110", {bus.iord, bus.mem_read, bus.mem_write}); end
      end
      if (i == 5) begin
        n_checks++;
        if (bus.mem_read !== 1'b0) begin n_fail++;
          $display("FAIL lw_wait_memread got=%b exp=0", bus.mem_read); end
      end
      if (i == 6) begin
        n_checks++;
        if ({bus.mem_to_reg, bus.reg_write, bus.reg_dst, bus.mem_write} !== 4'b1100) begin n_fail++;
          $display("FAIL lw_memwb got=%b exp=1100", {bus.mem_to_reg, bus.reg_write, bus.reg_dst, bus.mem_write}); end
      end
      tick();
    end
    n_checks++;
    if (bus.state_dbg !== FETCH) begin n_fail++;
      $display("FAIL lw_end got=%0d exp=%0d", bus.state_dbg, FETCH); end
  endtask

  task automatic test_branch(input logic z);
    logic [3:0] exp_s [4] = '{FETCH, FWAIT, DECODE, BRANCH};
    bus.op = 6'b000100; bus.zero = z;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bus.state_dbg !== exp_s[i]) begin n_fail++;
        $display("FAIL beq_state[%0d] got=%0d exp=%0d", i, bus.state_dbg, exp_s[i]); end
      if (i == 2) begin
        n_checks++;
        if ({bus.pc_we, bus.alu_src_b} !== 3'b011) begin n_fail++;
          $display("FAIL beq_decode got=%b exp=011", {bus.pc_we, bus.alu_src_b}); end
      end
      if (i == 3) begin
        n_checks++;
        if ({bus.pc_we, bus.pc_write_cond, bus.pc_source, bus.alu_control} !== {z, 1'b1, 2'b01, 3'b110}) begin
          n_fail++; $display("FAIL beq_branch zero=%b got=%b exp=%b", z,
            {bus.pc_we, bus.pc_write_cond, bus.pc_source, bus.alu_control}, {z, 1'b1, 2'b01, 3'b110}); end
      end
      tick();
    end
    n_checks++;
    if (bus.state_dbg !== FETCH) begin n_fail++;
      $display("FAIL beq_end got=%0d exp=%0d", bus.state_dbg, FETCH); end
    bus.zero = 1'b0;
  endtask

  task automatic test_jump();
    bus.op = 6'b000010;
    tick(); tick(); tick();
    n_checks++;
    if ({bus.state_dbg, bus.pc_source, bus.pc_we, bus.pc_write} !== {JUMP, 2'b10, 1'b1, 1'b1}) begin n_fail++;
      $display("FAIL jump got=%b exp=%b", {bus.state_dbg, bus.pc_source, bus.pc_we, bus.pc_write},
               {JUMP, 2'b10, 1'b1, 1'b1}); end
    tick();
    n_checks++;
    if (bus.state_dbg !== FETCH) begin n_fail++;
      $display("FAIL jump_end got=%0d exp=%0d", bus.state_dbg, FETCH); end
  endtask

  task automatic test_sw();
    int wr_cycles = 0;
    int both = 0;
    bus.op = 6'b101011;
    for (int i = 0; i < 5; i++) begin
      if (bus.mem_write === 1'b1) wr_cycles++;
      if (bus.mem_write === 1'b1 && bus.reg_write === 1'b1) both++;
      if (i == 4) begin
        n_checks++;
        if ({bus.state_dbg, bus.iord, bus.mem_read} !== {MEMWR, 2'b11}) begin n_fail++;
          $display("FAIL sw_memwr got=%b exp=%b", {bus.state_dbg, bus.iord, bus.mem_read}, {MEMWR, 2'b11}); end
      end
      tick();
    end
    n_checks++;
    if (wr_cycles !== 1 || both !== 0) begin n_fail++;
      $display("FAIL sw_write_count got=%0d/%0d exp=1/0", wr_cycles, both); end
    n_checks++;
    if (bus.state_dbg !== FETCH) begin n_fail++;
      $display("FAIL sw_end got=%0d exp=%0d", bus.state_dbg, FETCH); end
  endtask

  task automatic test_addi();
    bus.op = 6'b001000;
    tick(); tick(); tick();
    n_checks++;
    if ({bus.state_dbg, bus.alu_src_a, bus.alu_src_b, bus.alu_control} !== {ADDIEX, 1'b1, 2'b10, 3'b010}) begin
      n_fail++; $display("FAIL addi_ex got=%b", {bus.state_dbg, bus.alu_src_a, bus.alu_src_b, bus.alu_control}); end
    tick();
    n_checks++;
    if ({bus.state_dbg, bus.reg_write, bus.reg_dst, bus.mem_to_reg} !== {ADDIWB, 3'b100}) begin
      n_fail++; $display("FAIL addi_wb got=%b exp=%b", {bus.state_dbg, bus.reg_write, bus.reg_dst, bus.mem_to_reg},
                         {ADDIWB, 3'b100}); end
    tick();
    n_checks++;
    if (bus.state_dbg !== FETCH) begin n_fail++;
      $display("FAIL addi_end got=%0d exp=%0d", bus.state_dbg, FETCH); end
  endtask

  task automatic test_bad_funct();
    bus.op = 6'b000000; bus.funct = 6'b000000;
    tick(); tick(); tick(); tick();
    n_checks++;
    if ({bus.state_dbg, bus.illegal, bus.reg_write} !== {HALT, 2'b10}) begin n_fail++;
      $display("FAIL bad_funct got=%b exp=%b", {bus.state_dbg, bus.illegal, bus.reg_write}, {HALT, 2'b10}); end
    bus.funct = 6'b100000;
    do_reset();
  endtask

  task automatic test_halt();
    int bad = 0;
    bus.op = 6'b111111; bus.zero = 1'b1;
    tick(); tick(); tick();
    for (int i = 0; i < 20; i++) begin
      if (bus.state_dbg !== HALT || bus.illegal !== 1'b1 ||
          {bus.mem_read, bus.mem_write, bus.reg_write, bus.ir_write,
           bus.pc_write, bus.pc_write_cond, bus.pc_we} !== 7'b0) bad++;
      tick();
    end
    n_checks++;
    if (bad !== 0) begin n_fail++;
      $display("FAIL halt_hold bad_cycles got=%0d exp=0", bad); end
    bus.zero = 1'b0; bus.op = 6'b000000;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.state_dbg, bus.illegal, bus.mem_read} !== {FETCH, 2'b01}) begin n_fail++;
      $display("FAIL halt_reset got=%b exp=%b", {bus.state_dbg, bus.illegal, bus.mem_read}, {FETCH, 2'b01}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.op = 6'b100011;
    for (int i = 0; i < 6; i++) tick();
    n_checks++;
    if ({bus.state_dbg, bus.reg_write} !== {MEMWB, 1'b1}) begin n_fail++;
      $display("FAIL mid_pre got=%b exp=%b", {bus.state_dbg, bus.reg_write}, {MEMWB, 1'b1}); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.state_dbg, bus.reg_write, bus.mem_write, bus.pc_we, bus.mem_read} !== {FETCH, 4'b0001}) begin
      n_fail++; $display("FAIL mid_reset got=%b exp=%b",
        {bus.state_dbg, bus.reg_write, bus.mem_write, bus.pc_we, bus.mem_read}, {FETCH, 4'b0001}); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_checks++;
    if (bus.state_dbg !== FWAIT) begin n_fail++;
      $display("FAIL mid_resume got=%0d exp=%0d", bus.state_dbg, FWAIT); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw();
    test_branch(1'b1);
    test_branch(1'b0);
    test_jump();
    test_sw();
    test_addi();
    test_bad_funct();
    test_halt();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
